// File: rtl/write_queue.sv
// Wide-to-narrow write queue: accepts one IN_WIDTH word and streams it
// out LSB-first as MAX beats of OUT_WIDTH, chaining words without a bubble.
module write_queue #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 vld_in,
  output logic                 rdy_upward,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 vld_out,
  input  logic                 rdy_downward,
  output logic                 last_out
);

  localparam int MAX   = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = $clog2(MAX);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || MAX < 2) begin : g_bad_params
    $error("write_queue: IN_WIDTH must be a multiple of OUT_WIDTH with at least two beats");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] sreg_q,  sreg_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;

  logic last_beat;
  logic take_in;
  logic beat_done;

  assign last_beat = (state_q == SEND) && (cnt_q == CNT_W'(MAX - 1));

  // Outputs are gated by reset so a mid-word reset hides the pending beat at once.
  always_comb begin
    rdy_upward = !reset && ((state_q == IDLE) || (last_beat && rdy_downward));
    vld_out    = !reset && (state_q == SEND);
    last_out   = vld_out && last_beat;
    dout       = vld_out ? sreg_q[OUT_WIDTH-1:0] : '0;
  end

  assign take_in   = vld_in && rdy_upward;
  assign beat_done = vld_out && rdy_downward;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (take_in) begin
          sreg_d  = din;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat_done) begin
          if (!last_beat) begin
            sreg_d = sreg_q >> OUT_WIDTH;
            cnt_d  = cnt_q + CNT_W'(1);
          end else if (vld_in) begin
            // Final beat handshake doubles as the upstream accept.
            sreg_d = din;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_write_queue.sv
// Scoreboard bench for write_queue: words are split into expected beats on
// acceptance; an independent monitor pops and compares every output beat.
module tb_write_queue;

  localparam int IN_W  = 64;
  localparam int OUT_W = 32;
  localparam int NB    = IN_W / OUT_W;
  localparam int N_RANDOM   = 10000;
  localparam int CYCLE_LIMIT = 90000;

  logic             clk;
  logic             reset;
  logic [IN_W-1:0]  din;
  logic             vld_in;
  logic             rdy_upward;
  logic [OUT_W-1:0] dout;
  logic             vld_out;
  logic             rdy_downward;
  logic             last_out;

  write_queue #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .vld_in      (vld_in),
    .rdy_upward  (rdy_upward),
    .dout        (dout),
    .vld_out     (vld_out),
    .rdy_downward(rdy_downward),
    .last_out    (last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic             l;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int cycles = 0;
  int beats_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word becomes NB beats, lowest slice first, last flag on the final one.
  task automatic push_word(input logic [IN_W-1:0] w);
    beat_t b;
    for (int k = 0; k < NB; k++) begin
      b.d = w[k*OUT_W +: OUT_W];
      b.l = (k == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  // One cycle: drive inputs just after the edge, observe at the falling edge.
  task automatic tick(input logic rst, input logic vin, input logic [IN_W-1:0] d,
                      input logic rdn, output logic acc);
    @(posedge clk);
    #1;
    reset        = rst;
    vld_in       = vin;
    din          = d;
    rdy_downward = rdn;
    @(negedge clk);
    cycles++;
    acc = vin && rdy_upward && !reset;
    if (acc) push_word(d);
    if (reset) exp_q.delete();
  endtask

  // Monitor: compares every downstream handshake and checks that a stalled beat holds.
  initial begin : monitor
    logic             pend;
    logic [OUT_W-1:0] pend_d;
    logic             pend_l;
    beat_t            e;
    pend = 1'b0;
    pend_d = '0;
    pend_l = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        check("hold_vld", vld_out, 1);
        check("hold_dout", dout, pend_d);
        check("hold_last", last_out, pend_l);
      end
      if (vld_out && rdy_downward) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_data", dout, e.d);
          check("beat_last", last_out, e.l);
        end
        beats_seen++;
      end
      pend   = vld_out && !rdy_downward;
      pend_d = dout;
      pend_l = last_out;
    end
  end

  initial begin : stim
    logic             acc;
    logic [IN_W-1:0]  w;
    logic [IN_W-1:0]  words[3];
    logic [OUT_W-1:0] d0;
    int idx, first, lastc, nbeats, accepted, guard;

    reset = 1'b1;
    vld_in = 1'b0;
    din = '0;
    rdy_downward = 1'b0;

    // Reset with upstream valid held high: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, acc);
      check("rst_rdy_up", rdy_upward, 0);
      check("rst_vld_out", vld_out, 0);
      check("rst_last", last_out, 0);
      check("rst_dout", dout, 0);
    end
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    check("post_rst_rdy_up", rdy_upward, 1);
    check("post_rst_vld_out", vld_out, 0);

    // Single word.
    tick(1'b0, 1'b1, 64'h1111_2222_3333_4444, 1'b1, acc);
    check("single_acc", acc, 1);
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    check("single_b0", dout, 32'h3333_4444);
    check("single_b0_last", last_out, 0);
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    check("single_b1", dout, 32'h1111_2222);
    check("single_b1_last", last_out, 1);
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    check("single_done", vld_out, 0);

    // Three words back to back with both valids high.
    words[0] = 64'hA0A0_A1A1_A2A2_A3A3;
    words[1] = 64'hB0B0_B1B1_B2B2_B3B3;
    words[2] = 64'hC0C0_C1C1_C2C2_C3C3;
    idx = 0; first = -1; lastc = -1; nbeats = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1'b0, idx < 3, (idx < 3) ? words[idx] : '0, 1'b1, acc);
      if (vld_out) begin
        if (first < 0) first = c;
        lastc = c;
        nbeats++;
        check("b2b_rdy_up", rdy_upward, last_out);
      end
      if (acc) idx++;
    end
    check("b2b_words", idx, 3);
    check("b2b_beats", nbeats, 6);
    check("b2b_no_gap", lastc - first + 1, 6);

    // Downstream stall on beat 0.
    tick(1'b0, 1'b1, 64'h5555_6666_7777_8888, 1'b1, acc);
    tick(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, acc);
    d0 = dout;
    check("stall_d0", d0, 32'h7777_8888);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, acc);
      check("stall_vld", vld_out, 1);
      check("stall_dout", dout, d0);
      check("stall_last", last_out, 0);
      check("stall_rdy_up", rdy_upward, 0);
    end
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    check("stall_resume_b1", dout, 32'h5555_6666);
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    check("stall_idle", vld_out, 0);

    // Reset after beat 0: the high beat must be discarded.
    tick(1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, acc);
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    check("mid_b0", dout, 32'hCCCC_DDDD);
    tick(1'b1, 1'b0, '0, 1'b1, acc);
    check("mid_rst_vld", vld_out, 0);
    check("mid_rst_dout", dout, 0);
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    check("mid_post_vld", vld_out, 0);
    check("mid_post_rdy", rdy_upward, 1);
    tick(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, acc);
    check("mid_next_acc", acc, 1);
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    check("mid_next_b0", dout, 32'h9ABC_DEF0);
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    check("mid_next_b1", dout, 32'h1234_5678);

    // Random traffic.
    accepted = 0;
    while (accepted < N_RANDOM && cycles < CYCLE_LIMIT) begin
      w = {$urandom, $urandom};
      tick(1'b0, $urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0, acc);
      if (acc) accepted++;
    end
    check("random_accepted", accepted, N_RANDOM);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick(1'b0, 1'b0, '0, 1'b1, acc);
      guard++;
    end
    tick(1'b0, 1'b0, '0, 1'b1, acc);
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", vld_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
